// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: sequencer state encoding
// and the register-index width.
package pipe_ctrl_pkg;

   localparam int REG_W = 5;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Purely combinational decode-stage hazard detection: load-use and
// branch-operand dependencies. Register $0 never matches.
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] rs_d_i,
   input  logic [REG_W-1:0] rt_d_i,
   input  logic             branch_d_i,
   input  logic             reg_write_e_i,
   input  logic             mem_to_reg_e_i,
   input  logic [REG_W-1:0] write_reg_e_i,
   input  logic             mem_to_reg_m_i,
   input  logic [REG_W-1:0] write_reg_m_i,
   output logic             lwstall_o,
   output logic             brstall_o
);

   function automatic logic src_match(input logic [REG_W-1:0] dst,
                                      input logic [REG_W-1:0] rs,
                                      input logic [REG_W-1:0] rt);
      return (dst != '0) && ((dst == rs) || (dst == rt));
   endfunction

   logic e_hit;
   logic m_hit;

   assign e_hit = src_match(write_reg_e_i, rs_d_i, rt_d_i);
   assign m_hit = src_match(write_reg_m_i, rs_d_i, rt_d_i);

   assign lwstall_o = mem_to_reg_e_i & reg_write_e_i & e_hit;
   // A branch resolves in decode, so it must wait on any ALU result still in
   // EX as well as on a load still in MEM.
   assign brstall_o = branch_d_i & ((reg_write_e_i & e_hit) | (mem_to_reg_m_i & m_hit));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer and data-memory handshake for the 5-stage pipeline.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic [REG_W-1:0] RsD,
   input  logic [REG_W-1:0] RtD,
   input  logic             BranchD,
   input  logic             JumpD,
   input  logic             PCSrcD,
   input  logic             RegWriteE,
   input  logic             MemtoRegE,
   input  logic [REG_W-1:0] WriteRegE,
   input  logic             RegWriteM,
   input  logic             MemtoRegM,
   input  logic             MemWriteM,
   input  logic [REG_W-1:0] WriteRegM,
   input  logic             DMemReady,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             DMemReq,
   output logic             DMemErr,
   output logic [31:0]      StallCnt,
   output logic [31:0]      FlushCnt
);

   localparam logic [8:0] WAIT_LAST = 9'(TIMEOUT - 1);

   state_e     state_q;
   logic [8:0] wait_cnt_q;
   logic       dmem_err_q;

   logic memop_m;
   logic memstall;
   logic lwstall;
   logic brstall;
   logic reg_write_m_unused;

   assign memop_m            = MemtoRegM | MemWriteM;
   assign reg_write_m_unused = RegWriteM;

   hazard_detect u_hazard_detect (
      .rs_d_i         (RsD),
      .rt_d_i         (RtD),
      .branch_d_i     (BranchD),
      .reg_write_e_i  (RegWriteE),
      .mem_to_reg_e_i (MemtoRegE),
      .write_reg_e_i  (WriteRegE),
      .mem_to_reg_m_i (MemtoRegM),
      .write_reg_m_i  (WriteRegM),
      .lwstall_o      (lwstall),
      .brstall_o      (brstall)
   );

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         dmem_err_q <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (memop_m && !DMemReady) begin
                  state_q    <= MEM_WAIT;
                  wait_cnt_q <= '0;
               end
            end
            MEM_WAIT: begin
               if (DMemReady) begin
                  state_q <= RUN;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 9'd1;
                  if (wait_cnt_q == WAIT_LAST) begin
                     state_q    <= ERROR;
                     dmem_err_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q    <= ERROR;
               dmem_err_q <= 1'b1;
            end
         endcase
      end
   end

   // Handshake outputs are qualified by RSTn so an abandoned access drops
   // its request the moment reset asserts, not at the next edge.
   always_comb begin
      memstall = 1'b0;
      DMemReq  = 1'b0;
      case (state_q)
         RUN: begin
            DMemReq  = memop_m;
            memstall = memop_m & ~DMemReady;
         end
         MEM_WAIT: begin
            DMemReq  = 1'b1;
            memstall = ~DMemReady;
         end
         default: begin
            DMemReq  = 1'b0;
            memstall = 1'b1;
         end
      endcase
      DMemReq  = DMemReq & RSTn;
      memstall = memstall & RSTn;
   end

   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      if (memstall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
      end else if (lwstall || brstall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end else begin
         FlushD = PCSrcD | JumpD;
      end
   end

   assign DMemErr = dmem_err_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   assign stall_cnt_d = stall_cnt_q + {31'd0, StallF};
   assign flush_cnt_d = flush_cnt_q + {31'd0, (FlushD | FlushE)};

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign StallCnt = stall_cnt_q;
   assign FlushCnt = flush_cnt_q;
`else
   assign StallCnt = '0;
   assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a behavioural
// model of the memory access lifetime and decode hazard rules.
module tb_pipe_hazard_ctrl;

   localparam int TO = 4;

   logic       CLK = 1'b0;
   logic       RSTn = 1'b1;
   logic [4:0] RsD, RtD, WriteRegE, WriteRegM;
   logic       BranchD, JumpD, PCSrcD;
   logic       RegWriteE, MemtoRegE;
   logic       RegWriteM, MemtoRegM, MemWriteM;
   logic       DMemReady;
   logic       StallF, StallD, StallE, StallM, FlushD, FlushE, DMemReq, DMemErr;
   logic [31:0] StallCnt, FlushCnt;

   pipe_hazard_ctrl #(.TIMEOUT(TO)) dut (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .RsD       (RsD),
      .RtD       (RtD),
      .BranchD   (BranchD),
      .JumpD     (JumpD),
      .PCSrcD    (PCSrcD),
      .RegWriteE (RegWriteE),
      .MemtoRegE (MemtoRegE),
      .WriteRegE (WriteRegE),
      .RegWriteM (RegWriteM),
      .MemtoRegM (MemtoRegM),
      .MemWriteM (MemWriteM),
      .WriteRegM (WriteRegM),
      .DMemReady (DMemReady),
      .StallF    (StallF),
      .StallD    (StallD),
      .StallE    (StallE),
      .StallM    (StallM),
      .FlushD    (FlushD),
      .FlushE    (FlushE),
      .DMemReq   (DMemReq),
      .DMemErr   (DMemErr),
      .StallCnt  (StallCnt),
      .FlushCnt  (FlushCnt)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: an access is either absent, outstanding (with the number of
   // unready wait cycles spent so far), or has timed out permanently.
   bit          m_busy;
   bit          m_err;
   int          m_wait;
   logic [31:0] m_scnt;
   logic [31:0] m_fcnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit hits(input logic [4:0] d, input logic [4:0] rs, input logic [4:0] rt);
      return (d != 5'd0) && (d == rs || d == rt);
   endfunction

   function automatic logic [7:0] dut_ctl();
      return {StallF, StallD, StallE, StallM, FlushD, FlushE, DMemReq, DMemErr};
   endfunction

   task automatic model_reset();
      m_busy = 0;
      m_err  = 0;
      m_wait = 0;
      m_scnt = 0;
      m_fcnt = 0;
   endtask

   // Expected {StallF,StallD,StallE,StallM,FlushD,FlushE,DMemReq,DMemErr}.
   function automatic logic [7:0] model_ctl();
      bit memop, want, mstall, haz;
      logic [7:0] c;
      memop  = MemtoRegM | MemWriteM;
      want   = m_busy || memop;
      mstall = RSTn && (m_err || (want && !DMemReady));
      haz    = (MemtoRegE && RegWriteE && hits(WriteRegE, RsD, RtD)) ||
               (BranchD && ((RegWriteE && hits(WriteRegE, RsD, RtD)) ||
                            (MemtoRegM && hits(WriteRegM, RsD, RtD))));
      c = 8'd0;
      if (mstall)   c[7:2] = 6'b111100;
      else if (haz) c[7:2] = 6'b110001;
      else          c[3]   = PCSrcD | JumpD;
      c[1] = RSTn && !m_err && want;
      c[0] = m_err;
      return c;
   endfunction

   task automatic model_advance(input logic [7:0] c);
      bit memop;
      memop  = MemtoRegM | MemWriteM;
      m_scnt = m_scnt + {31'd0, c[7]};
      m_fcnt = m_fcnt + {31'd0, (c[3] | c[2])};
      if (!m_err) begin
         if (m_busy) begin
            if (DMemReady) m_busy = 0;
            else begin
               m_wait++;
               if (m_wait == TO) m_err = 1;
            end
         end else if (memop && !DMemReady) begin
            m_busy = 1;
            m_wait = 0;
         end
      end
   endtask

   // Called at posedge+1 with inputs already applied; ends at next posedge+1.
   task automatic step(input string tag, output logic [7:0] act);
      logic [7:0] e;
      #1;
      e   = model_ctl();
      act = dut_ctl();
      chk($sformatf("%s.ctl", tag), {24'd0, act}, {24'd0, e});
`ifdef HAZARD_PERF_CNT_EN
      chk($sformatf("%s.scnt", tag), StallCnt, m_scnt);
      chk($sformatf("%s.fcnt", tag), FlushCnt, m_fcnt);
`else
      chk($sformatf("%s.scnt", tag), StallCnt, 32'd0);
      chk($sformatf("%s.fcnt", tag), FlushCnt, 32'd0);
`endif
      model_advance(e);
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      RsD = 0; RtD = 0; WriteRegE = 0; WriteRegM = 0;
      BranchD = 0; JumpD = 0; PCSrcD = 0;
      RegWriteE = 0; MemtoRegE = 0;
      RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0;
      DMemReady = 0;
   endtask

   task automatic do_reset(input string tag);
      clear_inputs();
      RSTn = 1'b0;
      model_reset();
      #1;
      chk($sformatf("%s.ctl", tag), {24'd0, dut_ctl()}, 32'd0);
      chk($sformatf("%s.cnt", tag), StallCnt | FlushCnt, 32'd0);
      @(negedge CLK);
      RSTn = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   logic [7:0] act;
   int         req_n, sm_n;

   initial begin
      clear_inputs();
      #3;
      do_reset("reset");
      step("idle0", act);
      chk("idle0.zero", {24'd0, act}, 32'd0);
      step("idle1", act);

      MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; RsD = 8;
      step("lw", act);
      chk("lw.fixed", {24'd0, act}, 32'h0000_00C4);
      WriteRegE = 0;
      step("lw_r0", act);
      chk("lw_r0.fixed", {24'd0, act}, 32'd0);

      WriteRegE = 8; PCSrcD = 1;
      step("lw_pcsrc", act);
      chk("lw_pcsrc.fixed", {24'd0, act}, 32'h0000_00C4);
      clear_inputs();
      PCSrcD = 1;
      step("pcsrc", act);
      chk("pcsrc.fixed", {24'd0, act}, 32'h0000_0008);
      clear_inputs();
      BranchD = 1; RtD = 5; MemtoRegM = 0; RegWriteE = 1; WriteRegE = 5;
      step("br_e", act);
      clear_inputs();

      req_n = 0; sm_n = 0;
      MemtoRegM = 1;
      for (int i = 0; i < 4; i++) begin
         DMemReady = (i == 3);
         step($sformatf("mem3_%0d", i), act);
         req_n += act[1];
         sm_n  += act[4];
      end
      MemtoRegM = 0; DMemReady = 0;
      step("mem3_done", act);
      req_n += act[1];
      chk("mem3.req_cycles", req_n, 4);
      chk("mem3.stallm_cycles", sm_n, 3);

      MemWriteM = 1; DMemReady = 1;
      step("mem1", act);
      chk("mem1.nostall", {31'd0, act[4]}, 32'd0);
      DMemReady = 0; MemWriteM = 0;
      DMemReady = 1;
      step("ready_ignored", act);
      DMemReady = 0;

      MemWriteM = 1;
      step("midrst_a", act);
      step("midrst_b", act);
      RSTn = 1'b0;
      model_reset();
      #1;
      chk("midrst.req", {31'd0, DMemReq}, 32'd0);
      chk("midrst.stallm", {31'd0, StallM}, 32'd0);
      @(negedge CLK);
      RSTn = 1'b1;
      @(posedge CLK);
      #1;
      step("midrst_fresh", act);
      chk("midrst_fresh.req", {31'd0, act[1]}, 32'd1);
      DMemReady = 1;
      step("midrst_done", act);

      for (int blk = 0; blk < 4; blk++) begin
         do_reset($sformatf("rrst%0d", blk));
         for (int i = 0; i < 150; i++) begin
            RsD       = 5'($urandom_range(0, 3));
            RtD       = 5'($urandom_range(0, 3));
            WriteRegE = 5'($urandom_range(0, 3));
            WriteRegM = 5'($urandom_range(0, 3));
            BranchD   = ($urandom_range(0, 3) == 0);
            JumpD     = ($urandom_range(0, 7) == 0);
            PCSrcD    = ($urandom_range(0, 5) == 0);
            RegWriteE = 1'($urandom);
            MemtoRegE = 1'($urandom);
            RegWriteM = 1'($urandom);
            MemtoRegM = ($urandom_range(0, 4) == 0);
            MemWriteM = ($urandom_range(0, 5) == 0);
            DMemReady = ($urandom_range(0, 2) != 0);
            step($sformatf("rnd%0d_%0d", blk, i), act);
         end
      end

      do_reset("err_rst");
      MemWriteM = 1;
      for (int i = 0; i < 1 + TO; i++) begin
         step($sformatf("to_%0d", i), act);
         chk($sformatf("to_%0d.err", i), {31'd0, act[0]}, 32'd0);
      end
      MemWriteM = 0;
      step("err0", act);
      chk("err0.fixed", {24'd0, act}, 32'h0000_00F1);
      DMemReady = 1; PCSrcD = 1;
      step("err1", act);
      chk("err1.fixed", {24'd0, act}, 32'h0000_00F1);
      do_reset("err_clr");
      step("after_err", act);
      chk("after_err.zero", {24'd0, act}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It detects load-use and branch-operand hazards in decode, handles control-transfer flushes, and runs the data-memory handshake for the instruction held in the EX/MEM register. While memory is outstanding it freezes the pipeline, including the EX/MEM register, through per-stage stall and flush enables.

## Interface
- TIMEOUT, 255: maximum MEM_WAIT cycles before the error trap (legal range 1..255)
- CLK  in  1  pipeline clock; all state updates on the rising edge
- RSTn  in  1  asynchronous, active-low reset
- RsD, RtD  in  5  source registers of the instruction in decode
- BranchD, JumpD, PCSrcD  in  1  branch in decode / jump in decode / branch taken
- RegWriteE, MemtoRegE  in  1  EX-stage controls
- WriteRegE  in  5  EX-stage destination register
- RegWriteM, MemtoRegM, MemWriteM  in  1  MEM-stage controls
- WriteRegM  in  5  MEM-stage destination register
- DMemReady  in  1  data memory completes the current access this cycle
- StallF, StallD, StallE, StallM  out  1  hold the PC, IF/ID, ID/EX and EX/MEM registers
- FlushD, FlushE  out  1  clear IF/ID and ID/EX (bubble)
- DMemReq  out  1  data-memory access request
- DMemErr  out  1  sticky timeout flag
- StallCnt, FlushCnt  out  32  performance counters

## Operation
- memopM = MemtoRegM | MemWriteM.
- States: RUN, MEM_WAIT, ERROR. There is a 9-bit WaitCnt.
- RUN:
  - DMemReq = memopM.
  - If memopM & !DMemReady: memstall = 1; go to MEM_WAIT with WaitCnt = 0.
  - Otherwise there is no memstall.
- MEM_WAIT:
  - DMemReq = 1 and memstall = 1, except in a cycle where DMemReady = 1. In that cycle memstall = 0 and the state returns to RUN.
  - Otherwise WaitCnt increments each cycle. If WaitCnt == TIMEOUT-1 and DMemReady = 0, go to ERROR.
- ERROR:
  - DMemReq = 0, memstall = 1, DMemErr = 1.
  - The state is left only by reset.
- Load-use stall: lwstall = MemtoRegE & RegWriteE & (WriteRegE != 0) & (WriteRegE == RsD | WriteRegE == RtD).
- Branch stall: brstall = BranchD & ((RegWriteE & WriteRegE != 0 & WriteRegE ∈ {RsD, RtD}) | (MemtoRegM & WriteRegM != 0 & WriteRegM ∈ {RsD, RtD})).
- Priority: memstall, then lwstall|brstall, then flush.
  - memstall: StallF = StallD = StallE = StallM = 1; FlushD = FlushE = 0.
  - lwstall|brstall (no memstall): StallF = StallD = 1; FlushE = 1; StallE = StallM = 0; FlushD = 0.
  - Otherwise FlushD = PCSrcD | JumpD, and every other output is 0.
- Register $0 never causes a hazard.

## Timing
- All stall, flush and DMemReq outputs are combinational from state and inputs, with zero-cycle latency.
- State, WaitCnt, DMemErr and the counters are registered.
- Reset values: state RUN, WaitCnt 0, DMemErr 0, StallCnt 0, FlushCnt 0. With all inputs at 0, every output is 0.
- A single-cycle memory access (DMemReady = 1 in the first request cycle) costs no stall.
- An N-cycle access (ready in request cycle N) stalls N-1 cycles.
- DMemReq stays high continuously from the first request cycle until the ready cycle.
- ERROR is entered after exactly TIMEOUT stalled MEM_WAIT cycles without ready.
- DMemReady while in RUN with memopM = 0 is ignored.
- Asserting RSTn low mid-wait immediately forces RUN. Any outstanding access is abandoned: DMemReq falls asynchronously.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - StallCnt increments in every cycle with StallF = 1.
  - FlushCnt increments in every cycle with FlushD | FlushE.
  - Both counters wrap at 2^32.
- HAZARD_PERF_CNT_EN undefined: no counter registers; StallCnt and FlushCnt are tied to 0.
- The ports are present in both builds.

## Structure
- Package pipe_ctrl_pkg: state encoding (RUN = 0, MEM_WAIT = 1, ERROR = 2) and the register-index width constant (5).
- One sub-module, hazard_detect: the purely combinational lwstall/brstall logic.
- The FSM, the output priority mux and the counters live in pipe_hazard_ctrl.

## Test plan
- RSTn low, then release with all inputs 0: all outputs 0, state RUN, counters 0.
- MemtoRegE = RegWriteE = 1, WriteRegE = 8, RsD = 8: StallF = StallD = FlushE = 1, StallM = 0. Repeat with WriteRegE = 0: no stall.
- MemtoRegM = 1 and DMemReady low for 3 cycles, then high: DMemReq high for 4 cycles, StallM high for 3 cycles, StallCnt = 3 (macro on).
- TIMEOUT = 4, MemWriteM = 1, DMemReady held 0: ERROR after 4 MEM_WAIT cycles, DMemErr = 1, all stalls stuck high, DMemReq = 0. Reset clears all of it.
- PCSrcD = 1 concurrent with lwstall: FlushD = 0, FlushE = 1. PCSrcD = 1 alone: FlushD = 1, FlushCnt increments.
- RSTn pulsed low during MEM_WAIT: DMemReq and StallM drop at once; the next memopM starts a fresh request.
